// File: rtl/img_pkg.sv
// Shared image constants and pixel type for the line buffer and the 3x3 window filters.
package img_pkg;

   localparam int unsigned PIX_W      = 24;
   localparam int unsigned PIC_WIDTH  = 320;
   localparam int unsigned PIC_HEIGHT = 240;
   localparam int unsigned ADDR_W     = 9;

   // Lines that must be buffered before a full three-line window exists.
   localparam int unsigned PRIME_LINES = 2;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port, read-before-write.
module line_ram #(
   parameter int unsigned WIDTH  = img_pkg::PIX_W,
   parameter int unsigned ADDR_W = img_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem_q [Depth];
   logic [WIDTH-1:0] rdata_q;

   // No reset on the array or read register so the tools map this onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buf_3row.sv
// Three-row line buffer: turns a raster stream into column-aligned (line-2, line-1, line) taps.
// Optional BORDER_REPLICATE_EN also emits triples for lines 0 and 1 by replicating the top rows.
module line_buf_3row
   import img_pkg::*;
#(
   parameter int unsigned WIDTH      = img_pkg::PIX_W,
   parameter int unsigned PIC_WIDTH  = img_pkg::PIC_WIDTH,
   parameter int unsigned PIC_HEIGHT = img_pkg::PIC_HEIGHT,
   parameter int unsigned ADDR_W     = img_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sof_i,
   input  logic              pix_valid_i,
   input  logic [WIDTH-1:0]  pix_in_i,
   output logic [WIDTH-1:0]  row1_o,
   output logic [WIDTH-1:0]  row2_o,
   output logic [WIDTH-1:0]  row3_o,
   output logic              rows_valid_o,
   output logic [ADDR_W-1:0] line_idx_o
);

   localparam logic [ADDR_W-1:0] ColLast  = ADDR_W'(PIC_WIDTH - 1);
   localparam logic [ADDR_W-1:0] LineLast = ADDR_W'(PIC_HEIGHT - 1);
   localparam logic [ADDR_W-1:0] LineFull = ADDR_W'(PRIME_LINES);
   localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

   logic [ADDR_W-1:0] col_q, col_d, line_q, line_d;
   logic [ADDR_W-1:0] cur_col, cur_line;

   logic              v0_q, v1_q;
   logic [WIDTH-1:0]  pix0_q, pix1_q;
   logic [ADDR_W-1:0] col0_q, col1_q, line0_q, line1_q;

   logic [WIDTH-1:0]  rd_a, rd_b;

   logic [WIDTH-1:0]  row1_d, row2_d, row3_d;
   logic              valid_d;
   logic [WIDTH-1:0]  row1_q, row2_q, row3_q;
   logic              rows_valid_q;
   logic [ADDR_W-1:0] line_idx_q;

   // sof re-labels the pixel presented with it as column 0 of line 0.
   always_comb begin
      cur_col  = sof_i ? '0 : col_q;
      cur_line = sof_i ? '0 : line_q;
      col_d    = col_q;
      line_d   = line_q;
      if (pix_valid_i) begin
         if (cur_col == ColLast) begin
            col_d  = '0;
            line_d = (cur_line == LineLast) ? '0 : cur_line + AddrOne;
         end else begin
            col_d  = cur_col + AddrOne;
            line_d = cur_line;
         end
      end else if (sof_i) begin
         col_d  = '0;
         line_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         line_q <= '0;
      end else begin
         col_q  <= col_d;
         line_q <= line_d;
      end
   end

   // Stage 0 registers the accepted pixel and its position; stage 1 waits on the RAM read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q    <= 1'b0;
         pix0_q  <= '0;
         col0_q  <= '0;
         line0_q <= '0;
         v1_q    <= 1'b0;
         pix1_q  <= '0;
         col1_q  <= '0;
         line1_q <= '0;
      end else begin
         v0_q <= pix_valid_i;
         if (pix_valid_i) begin
            pix0_q  <= pix_in_i;
            col0_q  <= cur_col;
            line0_q <= cur_line;
         end
         v1_q <= v0_q;
         if (v0_q) begin
            pix1_q  <= pix0_q;
            col1_q  <= col0_q;
            line1_q <= line0_q;
         end
      end
   end

   // RAM_A holds the previous line, RAM_B the line before it.
   line_ram #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_ram_a (
      .clk     (clk),
      .we_i    (v0_q),
      .waddr_i (col0_q),
      .wdata_i (pix0_q),
      .re_i    (v0_q),
      .raddr_i (col0_q),
      .rdata_o (rd_a)
   );

   // RAM_A's old word only appears one cycle after its read, so RAM_B is written a stage later.
   line_ram #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_ram_b (
      .clk     (clk),
      .we_i    (v1_q),
      .waddr_i (col1_q),
      .wdata_i (rd_a),
      .re_i    (v0_q),
      .raddr_i (col0_q),
      .rdata_o (rd_b)
   );

   always_comb begin
      row1_d  = rd_b;
      row2_d  = rd_a;
      row3_d  = pix1_q;
      valid_d = v1_q && (line1_q >= LineFull);
`ifdef BORDER_REPLICATE_EN
      valid_d = v1_q;
      if (line1_q == '0) begin
         row1_d = pix1_q;
         row2_d = pix1_q;
      end else if (line1_q == AddrOne) begin
         row1_d = rd_a;
      end
`endif
   end

   // Taps only move when a pixel reaches the output stage, so they hold across input gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row1_q       <= '0;
         row2_q       <= '0;
         row3_q       <= '0;
         rows_valid_q <= 1'b0;
         line_idx_q   <= '0;
      end else begin
         rows_valid_q <= valid_d;
         if (v1_q) begin
            row1_q     <= row1_d;
            row2_q     <= row2_d;
            row3_q     <= row3_d;
            line_idx_q <= line1_q;
         end
      end
   end

   assign row1_o       = row1_q;
   assign row2_o       = row2_q;
   assign row3_o       = row3_q;
   assign rows_valid_o = rows_valid_q;
   assign line_idx_o   = line_idx_q;

endmodule

// File: tb/tb_line_buf_3row.sv
// Self-checking bench for line_buf_3row on a 4x4 picture; works with or without BORDER_REPLICATE_EN.
module tb_line_buf_3row;

   localparam int unsigned PW = 4;
   localparam int unsigned PH = 4;
   localparam int unsigned AW = 9;
   localparam int unsigned W  = 24;

`ifdef BORDER_REPLICATE_EN
   localparam int NTRIP = 16;
`else
   localparam int NTRIP = 8;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sof_i = 1'b0;
   logic          pix_valid_i = 1'b0;
   logic [W-1:0]  pix_in_i = '0;
   logic [W-1:0]  row1_o, row2_o, row3_o;
   logic          rows_valid_o;
   logic [AW-1:0] line_idx_o;

   always #5 clk = ~clk;

   line_buf_3row #(
      .WIDTH      (W),
      .PIC_WIDTH  (PW),
      .PIC_HEIGHT (PH),
      .ADDR_W     (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sof_i        (sof_i),
      .pix_valid_i  (pix_valid_i),
      .pix_in_i     (pix_in_i),
      .row1_o       (row1_o),
      .row2_o       (row2_o),
      .row3_o       (row3_o),
      .rows_valid_o (rows_valid_o),
      .line_idx_o   (line_idx_o)
   );

   // Expected output produced by one accepted pixel; full=0 means row1/row2 are don't-care.
   typedef struct packed {
      logic          acc;
      logic          vld;
      logic          full;
      logic [W-1:0]  r1;
      logic [W-1:0]  r2;
      logic [W-1:0]  r3;
      logic [AW-1:0] li;
   } rec_t;

   rec_t         q1, q2, eo;
   logic         ev;
   logic [W-1:0] img [PH][PW];
   int           m_col, m_line;
   int           n_cmp = 0;
   int           n_err = 0;

   function automatic logic [W-1:0] pat(input int i);
      return W'((i / PW) * 16 + (i % PW));
   endfunction

   task automatic mdl_reset();
      q1 = '0;
      q2 = '0;
      eo = '0;
      eo.full = 1'b1;
      ev = 1'b0;
      m_col = 0;
      m_line = 0;
   endtask

   // Drive one cycle, update the frame-store model, land 1 time unit after the edge.
   task automatic tick(input logic s, input logic v, input logic [W-1:0] p);
      rec_t nr;
      sof_i = s;
      pix_valid_i = v;
      pix_in_i = p;
      @(posedge clk);
      nr = '0;
      if (s) begin
         m_col = 0;
         m_line = 0;
      end
      if (v) begin
         img[m_line][m_col] = p;
         nr.acc = 1'b1;
         nr.r3 = p;
         nr.li = AW'(m_line);
         if (m_line >= 2) begin
            nr.r1 = img[m_line-2][m_col];
            nr.r2 = img[m_line-1][m_col];
            nr.vld = 1'b1;
         end
`ifdef BORDER_REPLICATE_EN
         else if (m_line == 1) begin
            nr.r1 = img[0][m_col];
            nr.r2 = img[0][m_col];
            nr.vld = 1'b1;
         end else begin
            nr.r1 = p;
            nr.r2 = p;
            nr.vld = 1'b1;
         end
`endif
         nr.full = nr.vld;
         m_col++;
         if (m_col == PW) begin
            m_col = 0;
            m_line++;
            if (m_line == PH) m_line = 0;
         end
      end
      ev = 1'b0;
      if (q2.acc) begin
         eo = q2;
         ev = q2.vld;
      end
      q2 = q1;
      q1 = nr;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({rows_valid_o, row1_o, row2_o, row3_o, line_idx_o} !== '0) begin
         n_err++;
         $display("FAIL reset_state got v=%0b %h/%h/%h l=%0d want all zero",
                  rows_valid_o, row1_o, row2_o, row3_o, line_idx_o);
      end
      rst_n = 1'b1;
      mdl_reset();
   endtask

   task automatic test_contiguous();
      int nv = 0;
      for (int t = 0; t < 19; t++) begin
         if (t < 16) tick(t == 0, 1'b1, pat(t));
         else tick(1'b0, 1'b0, '0);
         n_cmp++;
         if (rows_valid_o !== ev || row3_o !== eo.r3 || line_idx_o !== eo.li ||
             (eo.full && (row1_o !== eo.r1 || row2_o !== eo.r2))) begin
            n_err++;
            $display("FAIL contig t=%0d got v=%0b %h/%h/%h l=%0d want v=%0b %h/%h/%h l=%0d", t,
                     rows_valid_o, row1_o, row2_o, row3_o, line_idx_o, ev, eo.r1, eo.r2, eo.r3, eo.li);
         end
         if (rows_valid_o) nv++;
         if (t == 10 || t == 17) begin
            n_cmp++;
            if (!rows_valid_o || row1_o !== pat(t - 10) || row2_o !== pat(t - 6) ||
                row3_o !== pat(t - 2) || line_idx_o !== AW'((t == 10) ? 2 : 3)) begin
               n_err++;
               $display("FAIL contig_fixed t=%0d got v=%0b %h/%h/%h l=%0d", t, rows_valid_o,
                        row1_o, row2_o, row3_o, line_idx_o);
            end
         end
`ifdef BORDER_REPLICATE_EN
         if (t == 2 || t == 8) begin
            n_cmp++;
            if (!rows_valid_o || row1_o !== pat(t - 2 - ((t == 8) ? 4 : 0)) ||
                row2_o !== pat(t - 2 - ((t == 8) ? 4 : 0)) || row3_o !== pat(t - 2)) begin
               n_err++;
               $display("FAIL border_fixed t=%0d got v=%0b %h/%h/%h", t, rows_valid_o,
                        row1_o, row2_o, row3_o);
            end
         end
`endif
      end
      n_cmp++;
      if (nv != NTRIP) begin
         n_err++;
         $display("FAIL contig_count got %0d want %0d", nv, NTRIP);
      end
   endtask

   task automatic test_gaps();
      int   nv = 0;
      logic pv = 1'b0;
      for (int t = 0; t < 35; t++) begin
         if (t < 32 && t % 2 == 0) tick(t == 0, 1'b1, pat(t / 2));
         else tick(1'b0, 1'b0, W'($urandom));
         n_cmp++;
         if (rows_valid_o !== ev || row3_o !== eo.r3 || line_idx_o !== eo.li ||
             (eo.full && (row1_o !== eo.r1 || row2_o !== eo.r2))) begin
            n_err++;
            $display("FAIL gaps t=%0d got v=%0b %h/%h/%h l=%0d want v=%0b %h/%h/%h l=%0d", t,
                     rows_valid_o, row1_o, row2_o, row3_o, line_idx_o, ev, eo.r1, eo.r2, eo.r3, eo.li);
         end
         n_cmp++;
         if (rows_valid_o && pv) begin
            n_err++;
            $display("FAIL gaps_consecutive t=%0d got 2 valid cycles want 1", t);
         end
         pv = rows_valid_o;
         if (rows_valid_o) nv++;
      end
      n_cmp++;
      if (nv != NTRIP) begin
         n_err++;
         $display("FAIL gaps_count got %0d want %0d", nv, NTRIP);
      end
   endtask

   task automatic test_wrap();
      int nv2 = 0;
      for (int t = 0; t < 35; t++) begin
         if (t < 16) tick(t == 0, 1'b1, pat(t));
         else if (t < 32) tick(1'b0, 1'b1, W'(8'h80) + pat(t - 16));
         else tick(1'b0, 1'b0, '0);
         n_cmp++;
         if (rows_valid_o !== ev || row3_o !== eo.r3 || line_idx_o !== eo.li ||
             (eo.full && (row1_o !== eo.r1 || row2_o !== eo.r2))) begin
            n_err++;
            $display("FAIL wrap t=%0d got v=%0b %h/%h/%h l=%0d want v=%0b %h/%h/%h l=%0d", t,
                     rows_valid_o, row1_o, row2_o, row3_o, line_idx_o, ev, eo.r1, eo.r2, eo.r3, eo.li);
         end
         if (t >= 18 && rows_valid_o) nv2++;
         if (t == 26) begin
            n_cmp++;
            if (!rows_valid_o || row1_o !== W'(8'h80) || row3_o !== W'(8'ha0)) begin
               n_err++;
               $display("FAIL wrap_frame2 got v=%0b row1=%h row3=%h want v=1 row1=000080 row3=0000a0",
                        rows_valid_o, row1_o, row3_o);
            end
         end
      end
      n_cmp++;
      if (nv2 != NTRIP) begin
         n_err++;
         $display("FAIL wrap_count got %0d want %0d", nv2, NTRIP);
      end
   endtask

   task automatic test_sof_restart();
      int nv_mask = 0;
      for (int t = 0; t < 28; t++) begin
         if (t < 25) tick(t == 0 || t == 9, 1'b1, pat(t));
         else tick(1'b0, 1'b0, '0);
         n_cmp++;
         if (rows_valid_o !== ev || row3_o !== eo.r3 || line_idx_o !== eo.li ||
             (eo.full && (row1_o !== eo.r1 || row2_o !== eo.r2))) begin
            n_err++;
            $display("FAIL sof_restart t=%0d got v=%0b %h/%h/%h l=%0d want v=%0b %h/%h/%h l=%0d", t,
                     rows_valid_o, row1_o, row2_o, row3_o, line_idx_o, ev, eo.r1, eo.r2, eo.r3, eo.li);
         end
         if (t >= 11 && t <= 18 && rows_valid_o) nv_mask++;
         if (t == 19) begin
            n_cmp++;
            if (!rows_valid_o || row1_o !== pat(9) || row2_o !== pat(13) || row3_o !== pat(17) ||
                line_idx_o !== AW'(2)) begin
               n_err++;
               $display("FAIL sof_restart_first got v=%0b %h/%h/%h l=%0d want 1 %h/%h/%h l=2",
                        rows_valid_o, row1_o, row2_o, row3_o, line_idx_o, pat(9), pat(13), pat(17));
            end
         end
      end
`ifndef BORDER_REPLICATE_EN
      n_cmp++;
      if (nv_mask != 0) begin
         n_err++;
         $display("FAIL sof_restart_mask got %0d valid want 0", nv_mask);
      end
`endif
   endtask

   task automatic test_async_reset();
      int nv = 0;
      int first_t = -1;
      for (int t = 0; t < 11; t++) tick(t == 0, 1'b1, pat(t));
      sof_i = 1'b0;
      pix_valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rows_valid_o, row1_o, row2_o, row3_o, line_idx_o} !== '0) begin
         n_err++;
         $display("FAIL async_reset got v=%0b %h/%h/%h l=%0d want all zero",
                  rows_valid_o, row1_o, row2_o, row3_o, line_idx_o);
      end
      mdl_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int t = 0; t < 15; t++) begin
         if (t < 12) tick(t == 0, 1'b1, W'(8'hc0) + pat(t));
         else tick(1'b0, 1'b0, '0);
         n_cmp++;
         if (rows_valid_o !== ev || row3_o !== eo.r3 || line_idx_o !== eo.li ||
             (eo.full && (row1_o !== eo.r1 || row2_o !== eo.r2))) begin
            n_err++;
            $display("FAIL post_reset t=%0d got v=%0b %h/%h/%h l=%0d want v=%0b %h/%h/%h l=%0d", t,
                     rows_valid_o, row1_o, row2_o, row3_o, line_idx_o, ev, eo.r1, eo.r2, eo.r3, eo.li);
         end
         if (rows_valid_o) begin
            nv++;
            if (first_t < 0) first_t = t;
         end
      end
`ifndef BORDER_REPLICATE_EN
      n_cmp++;
      if (nv != 4 || first_t != 10) begin
         n_err++;
         $display("FAIL post_reset_mask got %0d valid first at %0d want 4 first at 10", nv, first_t);
      end
`endif
   endtask

   task automatic test_random();
      logic s, v;
      for (int t = 0; t < 400; t++) begin
         v = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 50) == 0);
         tick(s, v, W'($urandom));
         n_cmp++;
         if (rows_valid_o !== ev || row3_o !== eo.r3 || line_idx_o !== eo.li ||
             (eo.full && (row1_o !== eo.r1 || row2_o !== eo.r2))) begin
            n_err++;
            $display("FAIL random t=%0d got v=%0b %h/%h/%h l=%0d want v=%0b %h/%h/%h l=%0d", t,
                     rows_valid_o, row1_o, row2_o, row3_o, line_idx_o, ev, eo.r1, eo.r2, eo.r3, eo.li);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish want finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_contiguous();
      test_gaps();
      test_wrap();
      test_sof_restart();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
